perspective_projector: RTL and testbench



---
 rtl/perspective_projector.sv | 156 +++++++++++++++
 tb/tb_perspective_projector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/perspective_projector.sv
// ============================================================================
// Module  : perspective_projector
// Purpose : Perspective divide of camera-space vertices to saturated screen
//           coordinates using a shared-divisor restoring divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module perspective_projector #(
  parameter int W         = 16,
  parameter int FOCAL     = 256,
  parameter int SCREEN_CX = 320,
  parameter int SCREEN_CY = 240,
  parameter int ZMIN      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] vx,
  input  logic [W-1:0] vy,
  input  logic [W-1:0] vz,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sx,
  output logic [W-1:0] sy,
  output logic         clipped
);

  localparam int CW = $clog2(2*W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0]       c_CNT_LAST = CW'(2*W-1);
  localparam logic [W-1:0]        c_ONE      = W'(1);
  localparam logic [2*W-1:0]      c_FOCAL    = (2*W)'(FOCAL);
  localparam logic signed [W-1:0] c_ZMIN     = W'(ZMIN);
  localparam logic signed [W+1:0] c_CX       = (W+2)'(SCREEN_CX);
  localparam logic signed [W+1:0] c_CY       = (W+2)'(SCREEN_CY);
  localparam logic [2*W-1:0]      c_MAG_LIM  = {{(W+1){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] c_QMAX     = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] c_QMIN     = {3'b111, {(W-1){1'b0}}};

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_numx, r_numy;
  logic [W-1:0]   r_remx, r_remy;
  logic [W-1:0]   r_div;
  logic           r_sgnx, r_sgny;
  logic [W-1:0]   r_sx, r_sy;
  logic           r_clip;

  logic           w_accept, w_clip;
  logic [W-1:0]   w_absx, w_absy;
  logic [W:0]     w_shx, w_shy;
  logic           w_gex, w_gey;
  logic [W-1:0]   w_subx, w_suby;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_clip   = $signed(vz) < c_ZMIN;
  assign w_absx   = vx[W-1] ? (~vx + c_ONE) : vx;
  assign w_absy   = vy[W-1] ? (~vy + c_ONE) : vy;

  // One restoring step per numerator; quotient bits shift into the numerator LSB.
  assign w_shx  = {r_remx, r_numx[2*W-1]};
  assign w_shy  = {r_remy, r_numy[2*W-1]};
  assign w_gex  = w_shx >= {1'b0, r_div};
  assign w_gey  = w_shy >= {1'b0, r_div};
  assign w_subx = w_shx[W-1:0] - r_div;
  assign w_suby = w_shy[W-1:0] - r_div;

  function automatic logic signed [W+1:0] f_sat_q(input logic [2*W-1:0] mag, input logic neg);
    logic signed [W+1:0] v;
    if (mag >= c_MAG_LIM) v = neg ? c_QMIN : c_QMAX;
    else                  v = neg ? -$signed(mag[W+1:0]) : $signed(mag[W+1:0]);
    return v;
  endfunction

  function automatic logic [W-1:0] f_sat_out(input logic signed [W+1:0] s);
    logic [W-1:0] v;
    if (s > c_QMAX)      v = {1'b0, {(W-1){1'b1}}};
    else if (s < c_QMIN) v = {1'b1, {(W-1){1'b0}}};
    else                 v = s[W-1:0];
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_numx  <= '0;
      r_numy  <= '0;
      r_remx  <= '0;
      r_remy  <= '0;
      r_div   <= '0;
      r_sgnx  <= 1'b0;
      r_sgny  <= 1'b0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_clip  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_clip) begin
              r_clip  <= 1'b1;
              r_sx    <= '0;
              r_sy    <= '0;
              r_state <= S_DONE;
            end else begin
              r_numx  <= {{W{1'b0}}, w_absx} * c_FOCAL;
              r_numy  <= {{W{1'b0}}, w_absy} * c_FOCAL;
              // vz >= ZMIN here, so the divisor is a positive magnitude.
              r_div   <= vz;
              r_sgnx  <= vx[W-1];
              r_sgny  <= vy[W-1];
              r_remx  <= '0;
              r_remy  <= '0;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_numx <= {r_numx[2*W-2:0], w_gex};
          r_numy <= {r_numy[2*W-2:0], w_gey};
          r_remx <= w_gex ? w_subx : w_shx[W-1:0];
          r_remy <= w_gey ? w_suby : w_shy[W-1:0];
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == c_CNT_LAST) r_state <= S_FIN;
        end
        S_FIN: begin
          r_sx    <= f_sat_out(c_CX + f_sat_q(r_numx, r_sgnx));
          r_sy    <= f_sat_out(c_CY - f_sat_q(r_numy, r_sgny));
          r_clip  <= 1'b0;
          r_state <= S_DONE;
        end
        default: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sx        = r_sx;
  assign sy        = r_sy;
  assign clipped   = r_clip;

endmodule

`default_nettype wire

// File: tb/tb_perspective_projector.sv
// ============================================================================
// Module  : tb_perspective_projector
// Purpose : Self-checking bench: directed vector table, stall/reset sequences
//           and randomized vertices against an integer-arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_perspective_projector;

  localparam int W     = 16;
  localparam int FOCAL = 256;
  localparam int CX    = 320;
  localparam int CY    = 240;
  localparam int ZMIN  = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, clipped;
  logic [W-1:0] vx, vy, vz, sx, sy;

  always #5 clk = ~clk;

  perspective_projector #(
    .W(W), .FOCAL(FOCAL), .SCREEN_CX(CX), .SCREEN_CY(CY), .ZMIN(ZMIN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .vx(vx), .vy(vy), .vz(vz),
    .out_valid(out_valid), .out_ready(out_ready),
    .sx(sx), .sy(sy), .clipped(clipped)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x, y, z;
    int esx, esy;
    bit eclip;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic void model(input int x, input int y, input int z,
                                output int esx, output int esy, output bit eclip);
    longint qx, qy;
    if (z < ZMIN) begin
      eclip = 1'b1; esx = 0; esy = 0;
    end else begin
      qx = (longint'(x < 0 ? -x : x) * FOCAL) / z;
      qy = (longint'(y < 0 ? -y : y) * FOCAL) / z;
      if (x < 0) qx = -qx;
      if (y < 0) qy = -qy;
      eclip = 1'b0;
      esx = int'(clamp(CX + clamp(qx)));
      esy = int'(clamp(CY - clamp(qy)));
    end
  endfunction

  // Presents a vertex, accepts it, and waits (bounded) for out_valid.
  task automatic send(input int x, input int y, input int z, output int lat);
    vx = x[W-1:0]; vy = y[W-1:0]; vz = z[W-1:0];
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic check_out(input string tag, input int esx, input int esy, input bit eclip);
    check({tag, "_sx"}, $signed(sx), esx);
    check({tag, "_sy"}, $signed(sy), esy);
    check({tag, "_clip"}, clipped, eclip);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_out_valid_low", out_valid, 0);
    check("hs_in_ready_high", in_ready, 1);
  endtask

  initial begin
    int lat, esx, esy;
    bit eclip;
    logic [W-1:0] rx, ry;

    tbl[0] = '{100, 50, 200, 448, 176, 1'b0};
    tbl[1] = '{-100, -50, 200, 192, 304, 1'b0};
    tbl[2] = '{1, 1, 3, 405, 155, 1'b0};
    tbl[3] = '{-1, 0, 3, 235, 240, 1'b0};
    tbl[4] = '{5, 5, 0, 0, 0, 1'b1};
    tbl[5] = '{5, 5, -7, 0, 0, 1'b1};
    tbl[6] = '{32767, -32768, 1, 32767, 32767, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    vx = '0; vy = '0; vz = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check_out("rst", 0, 0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].x, tbl[i].y, tbl[i].z, lat);
      check("latency", lat, tbl[i].eclip ? 1 : 2*W+2);
      check_out("vec", tbl[i].esx, tbl[i].esy, tbl[i].eclip);
      handshake();
    end

    // Downstream stall: outputs must hold for 10 cycles.
    out_ready = 1'b0;
    send(-100, -50, 200, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check_out("stall", 192, 304, 1'b0);
    end
    handshake();
    send(1, 1, 3, lat);
    check_out("post_stall", 405, 155, 1'b0);
    handshake();

    // Reset while the divider counter sits at 10.
    vx = W'(100); vy = W'(50); vz = W'(200);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check_out("midrst", 0, 0, 1'b0);
    send(100, 50, 200, lat);
    check("midrst_latency", lat, 2*W+2);
    check_out("after_rst", 448, 176, 1'b0);
    handshake();

    for (int i = 0; i < 40; i++) begin
      int x, y, z, r;
      rx = W'($urandom);
      ry = W'($urandom);
      x = int'($signed(rx));
      y = int'($signed(ry));
      r = int'($urandom_range(0, 9));
      if (r == 0)      z = -int'($urandom_range(1, 32768));
      else if (r == 1) z = 0;
      else if (r < 5)  z = int'($urandom_range(1, 20));
      else             z = int'($urandom_range(1, 32767));
      model(x, y, z, esx, esy, eclip);
      send(x, y, z, lat);
      check("rand_latency", lat, eclip ? 1 : 2*W+2);
      check_out("rand", esx, esy, eclip);
      handshake();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
